tod_mux_n: RTL
==============

Name: tod_mux_n

Overview:
- Registered N-source Time-of-Day selector for E-tile Ethernet PTP datapaths (10G/25G/multi-rate). Selects one TX/RX 96-bit ToD pair from NUM_SRC ToD sources.
- Request/acknowledge switchover with output blanking.
- Re-qualifies the new source's valid before it drives the MAC ToD inputs, so a mid-stream rate change never presents a mixed or stale timestamp.
- Sits between the ToD master/slave instances and the MAC ToD ports.

Parameters:
- NUM_SRC, 2: number of ToD sources, 2..8.
- TOD_W, 96: ToD width; bits [95:48] seconds, [47:16] ns, [15:0] fractional ns; passed unmodified.
- SEL_W, 3: select width; must satisfy 2**SEL_W >= NUM_SRC.
- DEFAULT_SEL, 0: source selected out of reset.
- BLANK_CYC, 4: cycles tod_valid_out is held low during a switch, 1..255.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- tx_tod_in  in  NUM_SRC*TOD_W  TX ToD sources; source k at [k*TOD_W +: TOD_W].
- rx_tod_in  in  NUM_SRC*TOD_W  RX ToD sources, same packing.
- src_valid  in  NUM_SRC  per-source ToD-valid.
- sel_req  in  SEL_W  requested source index.
- sel_req_valid  in  1  one-cycle request strobe.
- tx_tod_out  out  TOD_W  selected TX ToD, registered.
- rx_tod_out  out  TOD_W  selected RX ToD, registered.
- tod_valid_out  out  1  outputs are from a qualified source.
- sel_active  out  SEL_W  index currently driving the outputs.
- switch_busy  out  1  high from request acceptance until the switch completes.
- switch_done  out  1  one-cycle pulse when a switch completes.
- sel_err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (rst=1 at a clk edge):
  - tx/rx_tod_out=0, tod_valid_out=0, sel_active=DEFAULT_SEL, switch_busy=0, switch_done=0, sel_err=0.
  - State=QUAL.
- Datapath:
  - In ACTIVE and QUAL, tx/rx_tod_out register the sel_active slice every cycle. Latency input to output is 1 cycle.
  - In BLANK, outputs hold their last registered value.
- States:
  - ACTIVE: tod_valid_out = src_valid[sel_active] (registered).
    - If src_valid[sel_active] drops, go to QUAL.
    - On an accepted request with sel_req != sel_active: latch sel_req into sel_active, load blank counter = BLANK_CYC-1, switch_busy=1, tod_valid_out=0, go to BLANK.
  - BLANK: counter decrements each cycle. At 0, go to QUAL.
  - QUAL: tod_valid_out=0. Stay until src_valid[sel_active]=1, then go to ACTIVE.
    - On exit, tod_valid_out=1 on the same edge.
    - If switch_busy=1: pulse switch_done and clear switch_busy on that edge.
- Request rules (evaluated only when sel_req_valid=1):
  - sel_req >= NUM_SRC: reject, pulse sel_err next cycle, no state change.
  - switch_busy=1: reject, pulse sel_err, in-flight switch unaffected.
  - sel_req == sel_active and not busy: accept with no blanking, pulse switch_done next cycle, valid unchanged.
  - Request arriving in QUAL while not busy: treated as a switch; go to BLANK.
- Timing: with the new source already valid, switch_done asserts BLANK_CYC+1 cycles after the request edge; tod_valid_out is low for exactly BLANK_CYC+1 cycles.
- Reset mid-switch: abandons the switch with no switch_done, returns to DEFAULT_SEL, QUAL.
- Simultaneous rst and sel_req_valid: reset wins.

Optional Feature:
- Macro TOD_MUX_SWITCH_CNT_EN.
- Defined:
  - Adds output switch_cnt [15:0].
  - Increments by 1 on each switch_done pulse for a real switch (sel changed), saturating at 16'hFFFF.
  - Cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, NUM_SRC=2, src_valid=2'b01, tx_tod_in[0]=96'h0000_0000_0001_0000_0000_0000 -> tod_valid_out=1 one cycle after rst drops; tx_tod_out equals source 0; sel_active=0.
- In ACTIVE, sel_req=1 pulsed, src_valid=2'b11, BLANK_CYC=4 -> tod_valid_out low exactly 5 cycles; outputs frozen during BLANK; switch_done 5 cycles after the request; tx_tod_out then tracks source 1.
- sel_req=1 with src_valid[1]=0 for 20 cycles, then 1 -> stays in QUAL with switch_busy=1; switch_done on the cycle after src_valid[1] rises.
- Second request during BLANK, and a request with sel_req=3 at NUM_SRC=2 -> sel_err pulse for each; sel_active and timing unaffected.
- Request equal to sel_active -> switch_done next cycle; tod_valid_out never drops; switch_cnt unchanged (macro on).
- rst asserted 2 cycles into BLANK with sel_active=1 -> next cycle: sel_active=0, outputs 0, switch_busy=0, no switch_done; with macro on, 65540 switches leave switch_cnt=16'hFFFF.

Source files
------------

// File: rtl/tod_mux_n.sv
// Registered N-source ToD selector with blanked, re-qualified switchover.
// Define TOD_MUX_SWITCH_CNT_EN to add the saturating switch_cnt output.
module tod_mux_n #(
  parameter int NUM_SRC     = 2,
  parameter int TOD_W       = 96,
  parameter int SEL_W       = 3,
  parameter int DEFAULT_SEL = 0,
  parameter int BLANK_CYC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*TOD_W-1:0] tx_tod_in,
  input  logic [NUM_SRC*TOD_W-1:0] rx_tod_in,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     sel_req_valid,
  output logic [TOD_W-1:0]         tx_tod_out,
  output logic [TOD_W-1:0]         rx_tod_out,
  output logic                     tod_valid_out,
  output logic [SEL_W-1:0]         sel_active,
  output logic                     switch_busy,
  output logic                     switch_done,
  output logic                     sel_err
`ifdef TOD_MUX_SWITCH_CNT_EN
  ,
  output logic [15:0]              switch_cnt
`endif
);

  localparam int NPAD = 2 ** SEL_W;
  localparam logic [SEL_W:0]   NSRC  = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] DSEL  = SEL_W'(DEFAULT_SEL);
  localparam logic [7:0]       BLOAD = 8'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    ACTIVE,
    BLANK,
    QUAL
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [TOD_W-1:0]  tx_q, tx_d;
  logic [TOD_W-1:0]  rx_q, rx_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fin;

  // Pad sources to a power of two so sel indexes without width mismatch
  logic [TOD_W-1:0]  tx_src [NPAD];
  logic [TOD_W-1:0]  rx_src [NPAD];
  logic [NPAD-1:0]   vld_pad;

  for (genvar k = 0; k < NPAD; k++) begin : g_src
    if (k < NUM_SRC) begin : g_on
      assign tx_src[k]  = tx_tod_in[k*TOD_W +: TOD_W];
      assign rx_src[k]  = rx_tod_in[k*TOD_W +: TOD_W];
      assign vld_pad[k] = src_valid[k];
    end else begin : g_off
      assign tx_src[k]  = '0;
      assign rx_src[k]  = '0;
      assign vld_pad[k] = 1'b0;
    end
  end

  logic cur_vld;
  logic req_bad;
  logic req_same;

  assign cur_vld  = vld_pad[sel_q];
  assign req_bad  = {1'b0, sel_req} >= NSRC;
  assign req_same = sel_req == sel_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    fin     = 1'b0;

    if (state_q != BLANK) begin
      tx_d = tx_src[sel_q];
      rx_d = rx_src[sel_q];
    end

    unique case (state_q)
      ACTIVE: begin
        vld_d = cur_vld;
        if (!cur_vld) state_d = QUAL;
      end
      BLANK: begin
        vld_d = 1'b0;
        if (cnt_q == 8'd0) state_d = QUAL;
        else               cnt_d   = cnt_q - 8'd1;
      end
      QUAL: begin
        vld_d = cur_vld;
        if (cur_vld) begin
          state_d = ACTIVE;
          if (busy_q) begin
            fin    = 1'b1;
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = QUAL;
        vld_d   = 1'b0;
      end
    endcase

    // A busy switch is never disturbed; same-index requests just acknowledge
    if (sel_req_valid) begin
      if (req_bad || busy_q) begin
        err_d = 1'b1;
      end else if (req_same) begin
        done_d = 1'b1;
      end else begin
        sel_d   = sel_req;
        cnt_d   = BLOAD;
        busy_d  = 1'b1;
        vld_d   = 1'b0;
        state_d = BLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= QUAL;
      sel_q   <= DSEL;
      tx_q    <= '0;
      rx_q    <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TOD_MUX_SWITCH_CNT_EN
  logic [15:0] swcnt_q, swcnt_d;

  always_comb begin
    swcnt_d = swcnt_q;
    if (fin && swcnt_q != 16'hFFFF) swcnt_d = swcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) swcnt_q <= 16'd0;
    else     swcnt_q <= swcnt_d;
  end

  assign switch_cnt = swcnt_q;
`else
  logic unused_fin;
  assign unused_fin = fin;
`endif

  assign tx_tod_out    = tx_q;
  assign rx_tod_out    = rx_q;
  assign tod_valid_out = vld_q;
  assign sel_active    = sel_q;
  assign switch_busy   = busy_q;
  assign switch_done   = done_q;
  assign sel_err       = err_q;

endmodule
